// File: rtl/bp_cfg_profile_sequencer.sv
// Runtime-selectable config profile store that replays a chosen profile as cfg-bus writes,
// either once per core set in a mask (lowest core first) or as a single broadcast pass.
module bp_cfg_profile_sequencer #(
  parameter int num_core_p       = 4,
  parameter int num_profiles_p   = 4,
  parameter int num_fields_p     = 8,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter logic [cfg_addr_width_p-1:0] cfg_base_addr_p = 'h0100,
  localparam int pid_w = (num_profiles_p > 1) ? $clog2(num_profiles_p) : 1,
  localparam int fid_w = (num_fields_p > 1) ? $clog2(num_fields_p) : 1,
  localparam int cid_w = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        prof_w_v_i,
  output logic                        prof_w_ready_o,
  input  logic [pid_w-1:0]            prof_w_id_i,
  input  logic [fid_w-1:0]            prof_w_field_i,
  input  logic [cfg_data_width_p-1:0] prof_w_data_i,
  input  logic                        start_v_i,
  output logic                        start_ready_o,
  input  logic [pid_w-1:0]            start_profile_i,
  input  logic                        start_bcast_i,
  input  logic [num_core_p-1:0]       start_core_mask_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {e_idle, e_send, e_done} state_e;

  state_e                      state_q, state_n;
  logic [cfg_data_width_p-1:0] table_q [num_profiles_p][num_fields_p];
  logic [pid_w-1:0]            profile_q;
  logic                        bcast_q;
  logic [num_core_p-1:0]       mask_q;
  logic [cid_w-1:0]            core_q;
  logic [fid_w-1:0]            field_q;

  logic             idle, prof_w_ok, start_ok, hs, last_field;
  logic [cid_w:0]   next_core;

  // Lowest set bit of the mask; zero when the mask is empty.
  function automatic logic [cid_w-1:0] lowest_set(input logic [num_core_p-1:0] m);
    logic [cid_w-1:0] r;
    r = '0;
    for (int i = num_core_p - 1; i >= 0; i--)
      if (m[i]) r = cid_w'(i);
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [cid_w:0] next_above(input logic [num_core_p-1:0] m,
                                                input logic [cid_w-1:0]      cur);
    logic [cid_w:0] r;
    r = '0;
    for (int i = num_core_p - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = {1'b1, cid_w'(i)};
    return r;
  endfunction

  assign idle       = (state_q == e_idle);
  assign prof_w_ok  = idle && prof_w_v_i && (int'(prof_w_id_i) < num_profiles_p)
                      && (int'(prof_w_field_i) < num_fields_p);
  assign start_ok   = idle && start_v_i && (int'(start_profile_i) < num_profiles_p);
  assign hs         = cfg_v_o && cfg_ready_i;
  assign last_field = (field_q == fid_w'(num_fields_p - 1));
  assign next_core  = next_above(mask_q, core_q);

  assign prof_w_ready_o = idle;
  assign start_ready_o  = idle;
  assign busy_o         = !idle;

  assign cfg_core_o = bcast_q ? {cfg_core_width_p{1'b1}} : cfg_core_width_p'(core_q);
  assign cfg_addr_o = cfg_base_addr_p + cfg_addr_width_p'(field_q);
  assign cfg_data_o = table_q[profile_q][field_q];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    cfg_v_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      e_idle: begin
        if (start_ok)
          state_n = (start_bcast_i || (|start_core_mask_i)) ? e_send : e_done;
      end
      e_send: begin
        cfg_v_o = 1'b1;
        if (cfg_ready_i && last_field && (bcast_q || !next_core[cid_w]))
          state_n = e_done;
      end
      e_done: begin
        done_o  = 1'b1;
        state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // Replay context: latched on start, stepped by each accepted cfg write.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      profile_q <= '0;
      bcast_q   <= 1'b0;
      mask_q    <= '0;
      core_q    <= '0;
      field_q   <= '0;
    end else if (start_ok) begin
      profile_q <= start_profile_i;
      bcast_q   <= start_bcast_i;
      mask_q    <= start_core_mask_i;
      core_q    <= start_bcast_i ? '0 : lowest_set(start_core_mask_i);
      field_q   <= '0;
    end else if (hs) begin
      if (last_field) begin
        field_q <= '0;
        if (!bcast_q && next_core[cid_w]) core_q <= next_core[cid_w-1:0];
      end else begin
        field_q <= field_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int p = 0; p < num_profiles_p; p++)
        for (int f = 0; f < num_fields_p; f++)
          table_q[p][f] <= '0;
    end else if (prof_w_ok) begin
      table_q[prof_w_id_i][prof_w_field_i] <= prof_w_data_i;
    end
  end

endmodule

// File: tb/tb_bp_cfg_profile_sequencer.sv
// Directed bench for bp_cfg_profile_sequencer: table of replay scenarios plus
// hand-written reset, stall and drop sequences.
module tb_bp_cfg_profile_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        prof_w_v_i;
  logic        prof_w_ready_o;
  logic [1:0]  prof_w_id_i;
  logic [2:0]  prof_w_field_i;
  logic [63:0] prof_w_data_i;
  logic        start_v_i;
  logic        start_ready_o;
  logic [1:0]  start_profile_i;
  logic        start_bcast_i;
  logic [3:0]  start_core_mask_i;
  logic        cfg_v_o;
  logic        cfg_ready_i;
  logic [7:0]  cfg_core_o;
  logic [15:0] cfg_addr_o;
  logic [63:0] cfg_data_o;
  logic        busy_o;
  logic        done_o;

  bp_cfg_profile_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .prof_w_v_i(prof_w_v_i), .prof_w_ready_o(prof_w_ready_o),
    .prof_w_id_i(prof_w_id_i), .prof_w_field_i(prof_w_field_i), .prof_w_data_i(prof_w_data_i),
    .start_v_i(start_v_i), .start_ready_o(start_ready_o), .start_profile_i(start_profile_i),
    .start_bcast_i(start_bcast_i), .start_core_mask_i(start_core_mask_i),
    .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_core_o(cfg_core_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int       prof;
    bit       bcast;
    bit [3:0] mask;
    bit       rnd;       // random cfg_ready_i stalls
    bit       inject;    // profile write + start attempted mid-replay
    bit       wr_same;   // profile write in the same cycle as the start
    int       exp_writes;
  } vec_t;

  vec_t        vecs [9];
  logic [63:0] model [4][8];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input int p, input int f, input logic [63:0] d);
    @(negedge clk_i);
    chk("prof_w_ready_idle", prof_w_ready_o, 1);
    prof_w_v_i = 1'b1; prof_w_id_i = 2'(p); prof_w_field_i = 3'(f); prof_w_data_i = d;
    @(posedge clk_i); #1;
    prof_w_v_i = 1'b0;
    model[p][f] = d;
  endtask

  task automatic replay(input vec_t v);
    logic [7:0]  ec [32];
    logic [15:0] ea [32];
    logic [63:0] ed [32];
    logic [7:0]  pc;
    logic [15:0] pa;
    logic [63:0] pd;
    int n, k, cyc;
    bit stalled, finished, rdy;
    if (v.wr_same) model[v.prof][0] = 64'hBEEF_0000_0000_0055;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if ((v.bcast && c == 0) || (!v.bcast && v.mask[c])) begin
        for (int f = 0; f < 8; f++) begin
          ec[n] = v.bcast ? 8'hFF : 8'(c);
          ea[n] = 16'h0100 + 16'(f);
          ed[n] = model[v.prof][f];
          n++;
        end
      end
    end
    @(negedge clk_i);
    chk("start_ready_idle", start_ready_o, 1);
    start_v_i = 1'b1; start_profile_i = 2'(v.prof);
    start_bcast_i = v.bcast; start_core_mask_i = v.mask;
    if (v.wr_same) begin
      prof_w_v_i = 1'b1; prof_w_id_i = 2'(v.prof); prof_w_field_i = 3'd0;
      prof_w_data_i = 64'hBEEF_0000_0000_0055;
    end
    cfg_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_v_i = 1'b0; prof_w_v_i = 1'b0;
    k = 0; cyc = 0; stalled = 0; finished = 0;
    pc = '0; pa = '0; pd = '0;
    while (cyc < 300 && !finished) begin
      @(negedge clk_i);
      cyc++;
      start_v_i = 1'b0; prof_w_v_i = 1'b0; start_core_mask_i = v.mask;
      if (cyc == 1) begin
        chk("first_cycle_v", cfg_v_o, (n != 0));
        chk("first_cycle_done", done_o, (n == 0));
      end
      if (stalled) begin
        chk("hold_core", cfg_core_o, pc);
        chk("hold_addr", cfg_addr_o, pa);
        chk("hold_data", cfg_data_o, pd);
      end
      if (done_o) begin
        chk("done_write_count", k, v.exp_writes);
        if (!v.rnd) chk("done_latency", cyc, v.exp_writes + 1);
        finished = 1;
      end else begin
        if (k < n) chk("no_bubble", cfg_v_o, 1);
        if (v.inject && k == 3 && cfg_v_o) begin
          chk("prof_w_ready_busy", prof_w_ready_o, 0);
          chk("start_ready_busy", start_ready_o, 0);
          chk("busy_in_send", busy_o, 1);
          prof_w_v_i = 1'b1; prof_w_id_i = 2'(v.prof); prof_w_field_i = 3'd2;
          prof_w_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
          start_v_i = 1'b1; start_profile_i = 2'd0; start_core_mask_i = 4'b1111;
        end
        rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cfg_ready_i = rdy;
        if (cfg_v_o) begin
          if (rdy) begin
            if (k < n) begin
              chk("wr_core", cfg_core_o, ec[k]);
              chk("wr_addr", cfg_addr_o, ea[k]);
              chk("wr_data", cfg_data_o, ed[k]);
            end else begin
              chk("extra_write", k, n);
            end
            k++;
          end
          stalled = !rdy;
          pc = cfg_core_o; pa = cfg_addr_o; pd = cfg_data_o;
        end else begin
          stalled = 0;
        end
      end
    end
    if (!finished) chk("replay_timeout", 0, 1);
    @(negedge clk_i);
    start_v_i = 1'b0; prof_w_v_i = 1'b0;
    chk("done_one_cycle", done_o, 0);
    chk("busy_after_done", busy_o, 0);
    chk("v_after_done", cfg_v_o, 0);
  endtask

  initial begin
    bit hit;
    reset_i = 1'b1; prof_w_v_i = 0; prof_w_id_i = 0; prof_w_field_i = 0; prof_w_data_i = 0;
    start_v_i = 0; start_profile_i = 0; start_bcast_i = 0; start_core_mask_i = 0; cfg_ready_i = 0;
    for (int p = 0; p < 4; p++) for (int f = 0; f < 8; f++) model[p][f] = '0;

    //                prof bcast mask     rnd inj same writes
    vecs[0] = '{1, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 16};
    vecs[1] = '{1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8};
    vecs[2] = '{1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{1, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 16};
    vecs[4] = '{1, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 16};
    vecs[5] = '{1, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 16};
    vecs[6] = '{2, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 16};
    vecs[7] = '{0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 8};
    vecs[8] = '{3, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 8};

    repeat (3) @(negedge clk_i);
    chk("rst_cfg_v", cfg_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_prof_w_ready", prof_w_ready_o, 1);
    chk("rst_start_ready", start_ready_o, 1);
    reset_i = 1'b0;

    for (int f = 0; f < 8; f++) write_word(1, f, 64'hA0 + 64'(f));
    for (int f = 0; f < 8; f++) write_word(2, f, 64'hDEAD_0000 + 64'(f));
    for (int f = 0; f < 8; f++) write_word(3, f, 64'h3333_0000_0000_0000 + 64'(f));

    for (int i = 0; i < 9; i++) replay(vecs[i]);

    // Reset mid-replay at core 2, field 3.
    @(negedge clk_i);
    start_v_i = 1'b1; start_profile_i = 2'd1; start_bcast_i = 1'b0;
    start_core_mask_i = 4'b0101; cfg_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_v_i = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk_i);
      if (cfg_v_o && cfg_core_o == 8'd2 && cfg_addr_o == 16'h0103) hit = 1;
    end
    chk("reset_point_reached", hit, 1);
    reset_i = 1'b1;
    #1;
    chk("midrst_cfg_v", cfg_v_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_start_ready", start_ready_o, 1);
    chk("midrst_prof_w_ready", prof_w_ready_o, 1);
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int p = 0; p < 4; p++) for (int f = 0; f < 8; f++) model[p][f] = '0;
    replay('{1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 8});
    replay('{2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
